// File: rtl/sd_ctrl_pkg.sv
// Shared types and sizing constants for the episode sequencer and its reward helper.
package sd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENV_RST = 3'd1,
        ST_REQ     = 3'd2,
        ST_APPLY   = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_UPDATE  = 3'd5,
        ST_NEXT    = 3'd6,
        ST_DONE    = 3'd7
    } sd_state_e;

    localparam int LEVEL_W    = 3;
    localparam int N_LANES    = 4;
    localparam int STATE_W    = 12;
    localparam int REWARD_MAX = 28;
    localparam int REWARD_W   = 5;

endpackage

// File: rtl/sd_reward_calc.sv
// Combinational reward: REWARD_MAX minus the sum of the four 3-bit congestion levels.
module sd_reward_calc
    import sd_ctrl_pkg::*;
(
    input  logic [STATE_W-1:0]  state,
    output logic [REWARD_W-1:0] reward
);

    logic [REWARD_W-1:0] sum_s;

    // Sum the lane levels; max 4*7 = 28 fits in REWARD_W bits, so no saturation.
    always_comb begin
        sum_s = {REWARD_W{1'b0}};
        for (int i = 0; i < N_LANES; i++) begin
            sum_s = sum_s + REWARD_W'(state[i*LEVEL_W +: LEVEL_W]);
        end
        reward = REWARD_W'(REWARD_MAX) - sum_s;
    end

endmodule

// File: rtl/sd_episode_ctrl.sv
// Training sequencer: runs episodes of agent-request / apply / settle / update steps
// against the two-intersection state converter.
module sd_episode_ctrl
    import sd_ctrl_pkg::*;
#(
    parameter int STEPS_PER_EP = 64,
    parameter int N_EPISODES   = 256,
    parameter int SETTLE       = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    output logic                act_req,
    input  logic                act_valid,
    input  logic [1:0]          act_A_in,
    input  logic [1:0]          act_B_in,
    output logic [1:0]          A_A,
    output logic [1:0]          A_B,
    output logic                env_rst,
    output logic                sd_en,
    output logic                learning,
    input  logic [STATE_W-1:0]  S_A,
    input  logic [STATE_W-1:0]  S_B,
    output logic                upd_valid,
    input  logic                upd_ready,
    output logic [STATE_W-1:0]  upd_S_A,
    output logic [STATE_W-1:0]  upd_S_B,
    output logic [REWARD_W-1:0] reward_A,
    output logic [REWARD_W-1:0] reward_B,
    output logic [7:0]          step_cnt,
    output logic [15:0]         ep_cnt,
    output logic                busy,
    output logic                done
);

    localparam logic [7:0]  LAST_STEP   = 8'(STEPS_PER_EP - 1);
    localparam logic [15:0] LAST_EP     = 16'(N_EPISODES - 1);
    localparam logic [3:0]  LAST_SETTLE = 4'(SETTLE - 1);

    sd_state_e           state_r;
    sd_state_e           state_nx_s;
    logic [3:0]          settle_cnt_r;
    logic [REWARD_W-1:0] reward_a_s;
    logic [REWARD_W-1:0] reward_b_s;
    logic                run_start_s;
    logic                act_hs_s;
    logic                capture_s;
    logic                advance_s;
    logic                last_step_s;
    logic                last_ep_s;

    sd_reward_calc u_reward_a (.state(S_A), .reward(reward_a_s));
    sd_reward_calc u_reward_b (.state(S_B), .reward(reward_b_s));

    // stop overrides every other event, including handshakes in the same cycle.
    assign run_start_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start && !stop;
    assign act_hs_s    = (state_r == ST_REQ) && act_valid && !stop;
    assign capture_s   = (state_r == ST_SETTLE) && (settle_cnt_r == LAST_SETTLE) && !stop;
    assign advance_s   = (state_r == ST_NEXT) && !stop;
    assign last_step_s = (step_cnt == LAST_STEP);
    assign last_ep_s   = (ep_cnt == LAST_EP);

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        if (stop) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) state_nx_s = ST_ENV_RST;
                    else       state_nx_s = state_r;
                end
                ST_ENV_RST: state_nx_s = ST_REQ;
                ST_REQ: begin
                    if (act_valid) state_nx_s = ST_APPLY;
                    else           state_nx_s = ST_REQ;
                end
                ST_APPLY: state_nx_s = ST_SETTLE;
                ST_SETTLE: begin
                    if (settle_cnt_r == LAST_SETTLE) state_nx_s = ST_UPDATE;
                    else                             state_nx_s = ST_SETTLE;
                end
                ST_UPDATE: begin
                    if (upd_ready) state_nx_s = ST_NEXT;
                    else           state_nx_s = ST_UPDATE;
                end
                ST_NEXT: begin
                    if (last_step_s && last_ep_s) state_nx_s = ST_DONE;
                    else if (last_step_s)         state_nx_s = ST_ENV_RST;
                    else                          state_nx_s = ST_REQ;
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State register and control outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            act_req   <= 1'b0;
            env_rst   <= 1'b0;
            sd_en     <= 1'b0;
            upd_valid <= 1'b0;
            learning  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            act_req   <= (state_nx_s == ST_REQ);
            env_rst   <= (state_nx_s == ST_ENV_RST);
            sd_en     <= (state_nx_s == ST_APPLY);
            upd_valid <= (state_nx_s == ST_UPDATE);
            learning  <= !((state_nx_s == ST_IDLE) || (state_nx_s == ST_DONE));
            busy      <= !((state_nx_s == ST_IDLE) || (state_nx_s == ST_DONE));
            done      <= (state_nx_s == ST_DONE);
        end
    end

    // Action capture, settle timer and update-record capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            A_A          <= 2'd0;
            A_B          <= 2'd0;
            settle_cnt_r <= 4'd0;
            upd_S_A      <= {STATE_W{1'b0}};
            upd_S_B      <= {STATE_W{1'b0}};
            reward_A     <= {REWARD_W{1'b0}};
            reward_B     <= {REWARD_W{1'b0}};
        end else begin
            if (act_hs_s) begin
                A_A <= act_A_in;
                A_B <= act_B_in;
            end
            if (state_r == ST_SETTLE) settle_cnt_r <= settle_cnt_r + 4'd1;
            else                      settle_cnt_r <= 4'd0;
            if (capture_s) begin
                upd_S_A  <= S_A;
                upd_S_B  <= S_B;
                reward_A <= reward_a_s;
                reward_B <= reward_b_s;
            end
        end
    end

    // Step/episode counters; they hold their value across an abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt <= 8'd0;
            ep_cnt   <= 16'd0;
        end else if (run_start_s) begin
            step_cnt <= 8'd0;
            ep_cnt   <= 16'd0;
        end else if (advance_s) begin
            if (!last_step_s) begin
                step_cnt <= step_cnt + 8'd1;
            end else if (!last_ep_s) begin
                step_cnt <= 8'd0;
                ep_cnt   <= ep_cnt + 16'd1;
            end else begin
                step_cnt <= step_cnt;
            end
        end
    end

endmodule

// File: tb/tb_sd_episode_ctrl.sv
// Self-checking bench for sd_episode_ctrl: randomized agent/update-unit timing and
// state values checked against a step-by-step reference of the training schedule.
module tb_sd_episode_ctrl;

    localparam int STEPS = 4;
    localparam int EPS   = 2;
    localparam int SETL  = 2;

    logic        clk = 1'b0;
    logic        rst, start, stop, act_req, act_valid;
    logic [1:0]  act_A_in, act_B_in, A_A, A_B;
    logic        env_rst, sd_en, learning, upd_valid, upd_ready, busy, done;
    logic [11:0] S_A, S_B, upd_S_A, upd_S_B;
    logic [4:0]  reward_A, reward_B;
    logic [7:0]  step_cnt;
    logic [15:0] ep_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_sd_en  = 0;
    int n_envrst = 0;

    sd_episode_ctrl #(.STEPS_PER_EP(STEPS), .N_EPISODES(EPS), .SETTLE(SETL)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .act_req(act_req), .act_valid(act_valid), .act_A_in(act_A_in), .act_B_in(act_B_in),
        .A_A(A_A), .A_B(A_B), .env_rst(env_rst), .sd_en(sd_en), .learning(learning),
        .S_A(S_A), .S_B(S_B), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_S_A(upd_S_A), .upd_S_B(upd_S_B), .reward_A(reward_A), .reward_B(reward_B),
        .step_cnt(step_cnt), .ep_cnt(ep_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Cycle counter and strobe pulse counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sd_en)   n_sd_en  <= n_sd_en + 1;
        if (env_rst) n_envrst <= n_envrst + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reward as stated: 28 minus the sum of four 3-bit lane levels.
    function automatic int ref_reward(input logic [11:0] s);
        int sum = 0;
        for (int i = 0; i < 4; i++) sum += (int'(s) >> (3 * i)) & 7;
        return 28 - sum;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_A_A"}, 32'(A_A), 32'd0);
        check({tag, "_A_B"}, 32'(A_B), 32'd0);
        check({tag, "_act_req"}, 32'(act_req), 32'd0);
        check({tag, "_env_rst"}, 32'(env_rst), 32'd0);
        check({tag, "_sd_en"}, 32'(sd_en), 32'd0);
        check({tag, "_learning"}, 32'(learning), 32'd0);
        check({tag, "_upd_valid"}, 32'(upd_valid), 32'd0);
        check({tag, "_upd_S_A"}, 32'(upd_S_A), 32'd0);
        check({tag, "_upd_S_B"}, 32'(upd_S_B), 32'd0);
        check({tag, "_reward_A"}, 32'(reward_A), 32'd0);
        check({tag, "_reward_B"}, 32'(reward_B), 32'd0);
        check({tag, "_step_cnt"}, 32'(step_cnt), 32'd0);
        check({tag, "_ep_cnt"}, 32'(ep_cnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_env_rst", 32'(env_rst), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_step_cnt", 32'(step_cnt), 32'd0);
        check("start_ep_cnt", 32'(ep_cnt), 32'd0);
    endtask

    task automatic wait_act_req();
        int n = 0;
        while (act_req !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("act_req_seen", 32'(act_req), 32'd1);
    endtask

    // One step from the agent's and update unit's point of view.
    // mode 0: full step; 1: stop during SETTLE; 2: rst while upd_valid is high.
    task automatic do_step(input int exp_ep, input int exp_st, input int act_dly, input int upd_dly,
                           input logic [1:0] a, input logic [1:0] b,
                           input logic [11:0] sa, input logic [11:0] sb,
                           input bit poke, input int mode, output int sd_cyc);
        int n;
        logic [11:0] junk;
        wait_act_req();
        check("step_cnt", 32'(step_cnt), 32'(exp_st));
        check("ep_cnt", 32'(ep_cnt), 32'(exp_ep));
        check("learning_run", 32'(learning), 32'd1);
        for (int i = 0; i < act_dly; i++) begin
            start = poke && (i == 0);
            @(negedge clk);
            start = 1'b0;
            check("act_req_hold", 32'(act_req), 32'd1);
            check("sd_en_early", 32'(sd_en), 32'd0);
        end
        act_A_in  = a;
        act_B_in  = b;
        act_valid = 1'b1;
        @(negedge clk);
        act_valid = 1'b0;
        act_A_in  = ~a;
        act_B_in  = ~b;
        sd_cyc    = cyc;
        check("sd_en_pulse", 32'(sd_en), 32'd1);
        check("A_A_capture", 32'(A_A), 32'(a));
        check("A_B_capture", 32'(A_B), 32'(b));
        check("act_req_drop", 32'(act_req), 32'd0);
        S_A = sa;
        S_B = sb;
        if (mode == 1) begin
            @(negedge clk);
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
        end else begin
            n = 0;
            while (upd_valid !== 1'b1 && n < 64) begin
                @(negedge clk);
                n++;
                check("sd_en_once", 32'(sd_en), 32'd0);
            end
            check("upd_valid_seen", 32'(upd_valid), 32'd1);
            check("upd_S_A", 32'(upd_S_A), 32'(sa));
            check("upd_S_B", 32'(upd_S_B), 32'(sb));
            check("reward_A", 32'(reward_A), 32'(ref_reward(sa)));
            check("reward_B", 32'(reward_B), 32'(ref_reward(sb)));
            junk = 12'($urandom);
            S_A  = junk;
            S_B  = ~junk;
            if (mode == 2) begin
                rst       = 1'b1;
                upd_ready = 1'b1;
                @(negedge clk);
                rst       = 1'b0;
                upd_ready = 1'b0;
            end else begin
                for (int i = 0; i < upd_dly; i++) begin
                    start = poke && (i == 0);
                    @(negedge clk);
                    start = 1'b0;
                    check("upd_valid_hold", 32'(upd_valid), 32'd1);
                    check("upd_S_A_stable", 32'(upd_S_A), 32'(sa));
                    check("reward_B_stable", 32'(reward_B), 32'(ref_reward(sb)));
                    check("A_A_stable", 32'(A_A), 32'(a));
                end
                upd_ready = 1'b1;
                @(negedge clk);
                upd_ready = 1'b0;
                check("upd_valid_drop", 32'(upd_valid), 32'd0);
                check("step_cnt_in_next", 32'(step_cnt), 32'(exp_st));
            end
        end
    endtask

    // Full training run; rand_mode=0 uses zero handshake delays and checks step timing.
    task automatic do_run(input bit rand_mode);
        int base_sd, base_env, prev, sc, ad, ud, n;
        logic [1:0] a, b;
        logic [11:0] sa, sb;
        bit poke;
        base_sd  = n_sd_en;
        base_env = n_envrst;
        prev     = 0;
        start_run();
        for (int ep = 0; ep < EPS; ep++) begin
            for (int st = 0; st < STEPS; st++) begin
                a    = 2'($urandom);
                b    = 2'($urandom);
                sa   = 12'($urandom);
                sb   = 12'($urandom);
                ad   = rand_mode ? int'($urandom_range(0, 3)) : 0;
                ud   = rand_mode ? int'($urandom_range(0, 3)) : 0;
                poke = rand_mode && ($urandom_range(0, 1) == 1);
                if (rand_mode && ep == 0 && st == 0) begin
                    ad = 5; a = 2'd2; b = 2'd1;
                end
                if (rand_mode && ep == 0 && st == 1) begin
                    sa = 12'hFFF; sb = 12'h000; ud = 3;
                end
                do_step(ep, st, ad, ud, a, b, sa, sb, poke, 0, sc);
                if (!rand_mode && !(ep == 0 && st == 0))
                    check("step_len", 32'(sc - prev), (st == 0) ? 32'd7 : 32'd6);
                prev = sc;
            end
        end
        n = 0;
        while (done !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("done_learning", 32'(learning), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_step_cnt", 32'(step_cnt), 32'(STEPS - 1));
        check("done_ep_cnt", 32'(ep_cnt), 32'(EPS - 1));
        check("sd_en_total", 32'(n_sd_en - base_sd), 32'(STEPS * EPS));
        check("env_rst_total", 32'(n_envrst - base_env), 32'(EPS));
    endtask

    initial begin
        int sc, base_sd;
        rst = 1'b1; start = 1'b0; stop = 1'b0; act_valid = 1'b0; upd_ready = 1'b0;
        act_A_in = 2'd0; act_B_in = 2'd0; S_A = 12'd0; S_B = 12'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        do_run(1'b0);
        do_run(1'b1);

        // Abort during SETTLE in the second episode; counters must hold.
        start_run();
        for (int st = 0; st < STEPS; st++)
            do_step(0, st, 0, 0, 2'($urandom), 2'($urandom), 12'($urandom), 12'($urandom), 1'b0, 0, sc);
        do_step(1, 0, 0, 0, 2'd1, 2'd3, 12'h123, 12'h456, 1'b0, 0, sc);
        do_step(1, 1, 1, 0, 2'd3, 2'd0, 12'h777, 12'h001, 1'b0, 1, sc);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_learning", 32'(learning), 32'd0);
        check("stop_upd_valid", 32'(upd_valid), 32'd0);
        check("stop_step_hold", 32'(step_cnt), 32'd1);
        check("stop_ep_hold", 32'(ep_cnt), 32'd1);
        base_sd = n_sd_en;
        repeat (10) @(negedge clk);
        check("stop_no_sd_en", 32'(n_sd_en - base_sd), 32'd0);
        check("stop_still_idle", 32'(busy), 32'd0);
        start_run();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_from_env_rst", 32'(busy), 32'd0);

        // start and stop together from IDLE: stop wins.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_busy", 32'(busy), 32'd0);
        check("start_stop_env_rst", 32'(env_rst), 32'd0);
        @(negedge clk);
        check("start_stop_idle", 32'(busy), 32'd0);

        // rst while upd_valid is high, with upd_ready in the same cycle.
        start_run();
        do_step(0, 0, 2, 0, 2'd3, 2'd2, 12'hABC, 12'h0F0, 1'b0, 2, sc);
        check_reset_outputs("mid_rst");
        @(negedge clk);
        check("mid_rst_idle", 32'(busy), 32'd0);
        check("mid_rst_step", 32'(step_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_episode_ctrl.md
# sd_episode_ctrl

Training sequencer for the traffic-state environment. Drives the two-intersection state converter (actions A_A/A_B, `learning` select, environment reset) and the Q-learning agent/update units. It runs a fixed number of episodes of a fixed number of steps. Each step follows the same sequence:
- request actions from the agent,
- apply them to the environment,
- wait for the state to settle,
- compute per-intersection rewards from the 4×3-bit congestion levels,
- hand the (state, reward) pair to the update unit.

## Interface
Parameters:
- STEPS_PER_EP, 64: steps per episode (≥1, ≤256).
- N_EPISODES, 256: episodes per training run (≥1, ≤65536).
- SETTLE, 2: wait cycles after applying an action before sampling state (≥1, ≤15).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a run when in IDLE or DONE, ignored otherwise.
- stop  in  1  pulse; aborts the run from any state.
- act_req  out  1  request for actions to the agent.
- act_valid  in  1  agent has actions; handshake completes on act_req & act_valid.
- act_A_in, act_B_in  in  2 each  agent actions, sampled at handshake.
- A_A, A_B  out  2 each  registered actions driven to the state converter.
- env_rst  out  1  one-cycle pulse that resets converter levels to 0.
- sd_en  out  1  one-cycle step strobe for the converter's level registers.
- learning  out  1  converter select; 1 = simulated levels, 0 = real traffic.
- S_A, S_B  in  12 each  converter states; 4 levels × 3 bits, lane0 in [2:0].
- upd_valid  out  1  update record valid.
- upd_ready  in  1  update unit accepts.
- upd_S_A, upd_S_B  out  12 each  state captured for the update.
- reward_A, reward_B  out  5 each  28 − sum of the four levels (0..28).
- step_cnt  out  8  current step in episode.
- ep_cnt  out  16  current episode.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.

## Operation
- FSM states: IDLE, ENV_RST, REQ, APPLY, SETTLE, UPDATE, NEXT, DONE.
- IDLE --start--> ENV_RST, with step_cnt and ep_cnt cleared. DONE --start--> the same.
- ENV_RST: env_rst=1 for exactly one cycle, then REQ.
- REQ: act_req held high until act_valid. On handshake, capture act_A_in/act_B_in into A_A/A_B, then APPLY.
- APPLY: sd_en=1 for exactly one cycle, then SETTLE. A_A/A_B stay stable from capture until the next handshake.
- SETTLE: count SETTLE cycles, then UPDATE. On UPDATE entry, register S_A/S_B into upd_S_*, and the computed rewards into reward_*.
- UPDATE: upd_valid held high, with data stable, until upd_ready. Handshake → NEXT.
- NEXT:
  - step_cnt==STEPS_PER_EP−1 and ep_cnt==N_EPISODES−1 → DONE;
  - else step_cnt==STEPS_PER_EP−1 → ep_cnt+1, step_cnt=0, ENV_RST;
  - else step_cnt+1 → REQ.
- DONE: done=1, learning=0. Holds until start.
- learning=1 in every state except IDLE and DONE.
- Reward width rules:
  - sum of four 3-bit levels is 5 bits, max 28;
  - reward = 5'd28 − sum;
  - no saturation needed.
- stop in any state → IDLE next cycle. act_req/upd_valid/sd_en/env_rst drop immediately. Counters hold their values.
- start and stop in the same cycle: stop wins.
- start while busy: ignored.

## Timing
- Reset values: state IDLE; A_A/A_B=0; all strobes/valids=0; learning=0; upd_S_*=0; reward_*=0; counters=0; busy=0; done=0.
- rst mid-run behaves exactly like the reset values above. No handshake completes on the reset cycle.
- All outputs are registered or decoded from registered state; no combinational input→output path.
- Minimum step length with act_valid and upd_ready tied high: REQ 1 + APPLY 1 + SETTLE SETTLE + UPDATE 1 + NEXT 1 = SETTLE+4 cycles. Episode boundary adds 1 cycle (ENV_RST).
- sd_en asserts exactly once per step. env_rst asserts exactly once per episode, before the first REQ.

## Structure
- Package sd_ctrl_pkg holds:
  - state enum;
  - LEVEL_W=3, N_LANES=4, STATE_W=12;
  - REWARD_MAX=28, REWARD_W=5.
- Sub-module sd_reward_calc: combinational 12-bit state → 5-bit reward. Instantiated twice (A and B).

## Test plan
- Reset, start, act_valid/upd_ready tied 1, SETTLE=2, STEPS_PER_EP=4, N_EPISODES=2 → 8 sd_en pulses, 2 env_rst pulses, 6-cycle steps, done after the last NEXT, learning low in DONE.
- Agent delays act_valid 5 cycles, act_A_in=2, act_B_in=1 → act_req held 5 cycles; A_A=2, A_B=1 the cycle after handshake; no sd_en before handshake.
- S_A=12'hFFF, S_B=12'h000 at sampling → reward_A=0, reward_B=28. Delay upd_ready 3 cycles → upd_valid and data stable throughout.
- stop asserted during SETTLE → IDLE next cycle, busy=0, no further sd_en; a subsequent start restarts with ep_cnt=0.
- start and stop in the same cycle from IDLE → remains IDLE. start pulses during REQ/UPDATE → ignored, counters unaffected.
- rst asserted while upd_valid=1 → all outputs at reset values next cycle, with upd_ready in that cycle not counted.
